// File: rtl/bk_adder_32b_pkg.sv
// Shared types for the Brent-Kung adder: operand width, tree depth and the
// generate/propagate pair with its prefix operator.
package bk_pkg;

    localparam int WIDTH = 32;
    localparam int LOG2W = 5;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    // (G,P) o (G',P') = (G | P&G', P&P'); hi is the more significant group.
    function automatic pg_t pg_combine(pg_t hi, pg_t lo);
        pg_t res;
        res.g = hi.g | (hi.p & lo.g);
        res.p = hi.p & lo.p;
        return res;
    endfunction

endpackage

// File: rtl/bk_adder_32b_if.sv
// Operand/result bundle for bk_adder_32b; the master drives operands and
// reads the registered 33-bit sum.
interface bk_adder_32b_if;
    import bk_pkg::*;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH:0]   sum;

    modport master (output a, output b, output cin, input sum);
    modport slave  (input a, input b, input cin, output sum);

endinterface

// File: rtl/bk_adder_32b_prefix_cell.sv
// One node of the prefix tree. A gray cell only produces a valid G; its P is
// forced low because the group it covers already reaches bit 0.
module bk_prefix_cell
    import bk_pkg::*;
#(
    parameter bit GRAY = 1'b0
) (
    input  pg_t hi,
    input  pg_t lo,
    output pg_t o
);

    // NOTE: every always_comb output gets a full default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        o = pg_combine(hi, lo);
        if (GRAY) begin
            o.p = 1'b0;
        end
    end

endmodule

// File: rtl/bk_adder_32b.sv
// 32-bit Brent-Kung parallel-prefix adder with carry-in; the 33-bit result
// (carry-out in the MSB) is registered, giving a fixed one-cycle latency.
module bk_adder_32b
    import bk_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    bk_adder_32b_if.slave  bus
);

    logic [WIDTH-1:0] p_bit;
    pg_t              pg0 [WIDTH];
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] fin_p;
    logic [WIDTH:0]   sum_d;
    logic [WIDTH:0]   sum_q;

    assign p_bit = bus.a ^ bus.b;

    // cin is folded into bit 0, so bit 0 is already a complete prefix and the
    // rest of the tree never has to see the carry-in.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pg0[i].g = bus.a[i] & bus.b[i];
            pg0[i].p = p_bit[i];
        end
        pg0[0].g = (bus.a[0] & bus.b[0]) | (p_bit[0] & bus.cin);
        pg0[0].p = 1'b0;
    end

    // Up-sweep: level k joins i = m*2^k - 1 with i - 2^(k-1).
    for (genvar k = 1; k <= LOG2W; k++) begin : g_up
        localparam int SPAN = 1 << k;
        localparam int OFF  = 1 << (k - 1);
        pg_t prev [WIDTH];
        pg_t node [WIDTH];

        if (k == 1) begin : g_src
            assign prev = pg0;
        end else begin : g_src
            assign prev = g_up[k-1].node;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if ((i + 1) % SPAN == 0) begin : g_cell
                bk_prefix_cell #(.GRAY(i == SPAN - 1)) u_cell (
                    .hi (prev[i]),
                    .lo (prev[i-OFF]),
                    .o  (node[i])
                );
            end else begin : g_pass
                assign node[i] = prev[i];
            end
        end
    end

    // Down-sweep: fills i = m*2^k + 2^(k-1) - 1 from an already complete prefix.
    for (genvar d = 1; d < LOG2W; d++) begin : g_dn
        localparam int OFF  = 1 << (LOG2W - 1 - d);
        localparam int SPAN = OFF * 2;
        pg_t prev [WIDTH];
        pg_t node [WIDTH];

        if (d == 1) begin : g_src
            assign prev = g_up[LOG2W].node;
        end else begin : g_src
            assign prev = g_dn[d-1].node;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (((i + 1) % SPAN == OFF) && (i >= SPAN)) begin : g_cell
                bk_prefix_cell #(.GRAY(1'b1)) u_cell (
                    .hi (prev[i]),
                    .lo (prev[i-OFF]),
                    .o  (node[i])
                );
            end else begin : g_pass
                assign node[i] = prev[i];
            end
        end
    end

    always_comb begin
        carry[0] = bus.cin;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i+1] = g_dn[LOG2W-1].node[i].g;
            fin_p[i]   = g_dn[LOG2W-1].node[i].p;
        end
        // Every final node spans down to bit 0, so no group propagate survives.
        assert (fin_p == '0);
        sum_d = {carry[WIDTH], p_bit ^ carry[WIDTH-1:0]};
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign bus.sum = sum_q;

endmodule

// File: tb/tb_bk_adder_32b.sv
// Directed-vector and random-stream bench for bk_adder_32b; inputs change on
// the falling edge and the registered sum is sampled on the falling edge.
module tb_bk_adder_32b;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [32:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    bk_adder_32b_if bus ();

    bk_adder_32b dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs [12];
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic [32:0] exp_prev;

        total = 0;
        bad   = 0;

        vecs[0]  = '{"ripple_cin1",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000};
        vecs[1]  = '{"ripple_cin0",  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33'h0_FFFF_FFFF};
        vecs[2]  = '{"max_operands", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF};
        vecs[3]  = '{"zero_cin1",    32'h0000_0000, 32'h0000_0000, 1'b1, 33'h0_0000_0001};
        vecs[4]  = '{"bit15_carry",  32'h0000_8000, 32'h0000_8000, 1'b0, 33'h0_0001_0000};
        vecs[5]  = '{"to_msb",       32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000};
        vecs[6]  = '{"alt_cin1",     32'h5555_5555, 32'hAAAA_AAAA, 1'b1, 33'h1_0000_0000};
        vecs[7]  = '{"all_zero",     32'h0000_0000, 32'h0000_0000, 1'b0, 33'h0_0000_0000};
        vecs[8]  = '{"no_carry",     32'h1234_5678, 32'h8765_4321, 1'b0, 33'h0_9999_9999};
        vecs[9]  = '{"msb_carry",    32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000};
        vecs[10] = '{"upper_ripple", 32'hFFFF_0000, 32'h0001_0000, 1'b0, 33'h1_0000_0000};
        vecs[11] = '{"nibble_mix",   32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b1, 33'h0_1E1E_1E1F};

        // Reset holds sum at zero even with a carrying operand pair applied.
        rst_n = 1'b0;
        drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_hold_%0d", i), bus.sum, 33'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_release", bus.sum, 33'h1_0000_0001);

        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].cin);
            @(negedge clk);
            check(vecs[i].name, bus.sum, vecs[i].exp);
        end

        // Back-to-back stream with a one-cycle reset pulse at vector 50.
        exp_prev = '0;
        for (int j = 0; j <= 100; j++) begin
            if (j > 0) begin
                check($sformatf("stream_%0d", j - 1), bus.sum, exp_prev);
            end
            if (j < 100) begin
                ra = $urandom;
                rb = $urandom;
                rc = 1'($urandom_range(0, 1));
                drive(ra, rb, rc);
                rst_n = (j == 50) ? 1'b0 : 1'b1;
                exp_prev = (j == 50) ? 33'h0 : ({1'b0, ra} + {1'b0, rb} + {32'h0, rc});
                @(negedge clk);
            end
        end
        rst_n = 1'b1;

        // First cycle after a mid-stream reset captures inputs with no recovery gap.
        rst_n = 1'b0;
        drive(32'hDEAD_BEEF, 32'h0000_0001, 1'b0);
        @(negedge clk);
        check("pulse_reset", bus.sum, 33'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("pulse_recover", bus.sum, 33'h0_DEAD_BEF0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
